// File: rtl/gpu_fixed_pkg.sv
// Shared fixed-point types for the GPU vertex pipeline (signed Q16.16).
package gpu_fixed_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } persp_state_t;

    localparam fixed_t ONE = 32'sh0001_0000;

    // Magnitude as an unsigned value, so -2^31 maps to 2^31 rather than overflowing
    function automatic logic [31:0] abs_mag(input fixed_t v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

endpackage

// File: rtl/perspective_divide_if.sv
// Vertex-in / NDC-out handshake bundle between the transform stage and rasteriser setup.
interface perspective_divide_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic signed [WIDTH-1:0] in_z;
    logic signed [WIDTH-1:0] in_w;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_x;
    logic signed [WIDTH-1:0] out_y;
    logic signed [WIDTH-1:0] out_z;
    logic                    out_wzero;

    modport master (
        output in_valid, in_x, in_y, in_z, in_w, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, out_wzero
    );

    modport slave (
        input  in_valid, in_x, in_y, in_z, in_w, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, out_wzero
    );
endinterface

// File: rtl/perspective_divide_div.sv
// Sequential signed Q16.16 divider: (|n| << FRAC_BITS) / |d|, sign applied afterwards.
// finished drops on the edge after start and rises 64 edges later.
module perspective_divide_div
    import gpu_fixed_pkg::abs_mag;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] num,
    input  logic signed [WIDTH-1:0] den,
    output logic signed [WIDTH-1:0] quotient,
    output logic                    finished
);
    localparam int         ACC_W      = WIDTH + FRAC_BITS;
    localparam logic [6:0] STEPS      = 7'(ACC_W);
    localparam logic [6:0] LAST_COUNT = 7'd63;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             neg_q, neg_d;
    logic [6:0]       count_q, count_d;
    logic             finished_q, finished_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] quot_mag;

    // acc_q starts as the shifted dividend and fills with quotient bits from the bottom
    always_comb begin
        acc_d      = acc_q;
        rem_d      = rem_q;
        den_d      = den_q;
        neg_d      = neg_q;
        count_d    = count_q;
        finished_d = finished_q;
        rem_shift  = {rem_q, acc_q[ACC_W-1]};
        rem_diff   = rem_shift - {1'b0, den_q};
        if (start) begin
            acc_d      = {abs_mag(num), {FRAC_BITS{1'b0}}};
            den_d      = abs_mag(den);
            neg_d      = num[WIDTH-1] ^ den[WIDTH-1];
            rem_d      = '0;
            count_d    = '0;
            finished_d = 1'b0;
        end else if (!finished_q) begin
            count_d = count_q + 7'd1;
            if (count_q < STEPS) begin
                if (!rem_diff[WIDTH]) begin
                    rem_d = rem_diff[WIDTH-1:0];
                    acc_d = {acc_q[ACC_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    acc_d = {acc_q[ACC_W-2:0], 1'b0};
                end
            end
            if (count_q == LAST_COUNT) begin
                finished_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            neg_q      <= 1'b0;
            count_q    <= '0;
            finished_q <= 1'b1;
        end else begin
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            neg_q      <= neg_d;
            count_q    <= count_d;
            finished_q <= finished_d;
        end
    end

    assign quot_mag = acc_q[WIDTH-1:0];
    assign quotient = neg_q ? -quot_mag : quot_mag;
    assign finished = finished_q;

endmodule

// File: rtl/perspective_divide.sv
// Clip-space vertex -> NDC (x/w, y/w, z/w), sharing one sequential divider over the three
// components. A w of exactly zero bypasses the divider and reports zeros with out_wzero.
module perspective_divide #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = gpu_fixed_pkg::FRAC_BITS
) (
    input  logic clk,
    input  logic rst_n,
    perspective_divide_if.slave bus
);
    import gpu_fixed_pkg::persp_state_t;
    import gpu_fixed_pkg::IDLE;
    import gpu_fixed_pkg::ISSUE;
    import gpu_fixed_pkg::WAIT;
    import gpu_fixed_pkg::OUTPUT;

    persp_state_t            state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d;
    logic signed [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic                    out_wzero_q, out_wzero_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    div_start_q, div_start_d;
    logic signed [WIDTH-1:0] div_num;
    logic signed [WIDTH-1:0] div_quot;
    logic                    div_finished;

    always_comb begin
        unique case (idx_q)
            2'd0:    div_num = x_q;
            2'd1:    div_num = y_q;
            default: div_num = z_q;
        endcase
    end

    perspective_divide_div #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_q),
        .num      (div_num),
        .den      (w_q),
        .quotient (div_quot),
        .finished (div_finished)
    );

    // WAIT is only entered after ISSUE, by which time the divider has cleared finished
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        w_d         = w_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        out_wzero_d = out_wzero_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        div_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d        = bus.in_x;
                    y_d        = bus.in_y;
                    z_d        = bus.in_z;
                    w_d        = bus.in_w;
                    idx_d      = 2'd0;
                    in_ready_d = 1'b0;
                    if (bus.in_w == '0) begin
                        out_x_d     = '0;
                        out_y_d     = '0;
                        out_z_d     = '0;
                        out_wzero_d = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end else begin
                        div_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_finished) begin
                    unique case (idx_q)
                        2'd0:    out_x_d = div_quot;
                        2'd1:    out_y_d = div_quot;
                        default: out_z_d = div_quot;
                    endcase
                    if (idx_q < 2'd2) begin
                        idx_d       = idx_q + 2'd1;
                        div_start_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        idx_d       = 2'd0;
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_wzero_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            w_q         <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_wzero_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            w_q         <= w_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_wzero_q <= out_wzero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            div_start_q <= div_start_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_z     = out_z_q;
    assign bus.out_wzero = out_wzero_q;

endmodule

// File: tb/tb_perspective_divide.sv
// Self-checking bench for perspective_divide: directed vertices with literal results plus
// randomized vertices, all checked every cycle against a behavioural divide/timing model.
module tb_perspective_divide;
    import gpu_fixed_pkg::*;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        wz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    perspective_divide_if #(.WIDTH(32)) bus ();

    perspective_divide #(
        .WIDTH     (32),
        .FRAC_BITS (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   due_cyc = 0;
    logic model_busy = 1'b0;
    exp_t model_exp = '0;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0b expected %0b", name, act, exp);
        end
    endtask

    // Plain-arithmetic Q16.16 divide: magnitude quotient truncated, wrapped to 32 bits, signed
    function automatic logic [31:0] model_div(input fixed_t n, input fixed_t d);
        longint      an;
        longint      ad;
        longint      q;
        logic [31:0] lo;
        an = (n < 0) ? -longint'(n) : longint'(n);
        ad = (d < 0) ? -longint'(d) : longint'(d);
        q  = (an <<< 16) / ad;
        lo = q[31:0];
        return ((n < 0) != (d < 0)) ? (32'd0 - lo) : lo;
    endfunction

    function automatic exp_t model_vertex(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic [31:0] w);
        exp_t e;
        if (w == 32'd0) begin
            e = '{x: 32'd0, y: 32'd0, z: 32'd0, wz: 1'b1};
        end else begin
            e.x  = model_div(x, w);
            e.y  = model_div(y, w);
            e.z  = model_div(z, w);
            e.wz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_fixed();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 32'h0004_0000);
            2:       v = 32'd0 - $urandom_range(1, 32'h0004_0000);
            default: v = $urandom_range(0, 32'h0100_0000) - 32'h0080_0000;
        endcase
        return v;
    endfunction

    // Compare process: at every falling edge the model says what the DUT must show, then
    // decides from the current inputs whether the coming rising edge accepts or transfers.
    initial begin
        logic exp_valid;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                model_busy = 1'b0;
                check_bit("rst_out_valid", bus.out_valid, 1'b0);
                check_bit("rst_in_ready", bus.in_ready, 1'b1);
                check_word("rst_out_x", bus.out_x, 32'd0);
                check_word("rst_out_y", bus.out_y, 32'd0);
                check_word("rst_out_z", bus.out_z, 32'd0);
                check_bit("rst_out_wzero", bus.out_wzero, 1'b0);
            end else begin
                exp_valid = model_busy && (cyc >= due_cyc);
                check_bit("out_valid", bus.out_valid, exp_valid);
                check_bit("in_ready", bus.in_ready, !model_busy);
                if (exp_valid) begin
                    check_word("out_x", bus.out_x, model_exp.x);
                    check_word("out_y", bus.out_y, model_exp.y);
                    check_word("out_z", bus.out_z, model_exp.z);
                    check_bit("out_wzero", bus.out_wzero, model_exp.wz);
                end else if (!model_busy) begin
                    check_bit("idle_out_wzero", bus.out_wzero, 1'b0);
                end
                if (exp_valid && bus.out_ready) begin
                    model_busy = 1'b0;
                end else if (!model_busy && bus.in_valid) begin
                    model_busy = 1'b1;
                    model_exp  = model_vertex(bus.in_x, bus.in_y, bus.in_z, bus.in_w);
                    due_cyc    = cyc + ((bus.in_w == 32'd0) ? 1 : 199);
                end
            end
        end
    end

    // Present one vertex until the DUT takes it, then scramble the bus so stale data shows up
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [31:0] w);
        int n = 0;
        @(posedge clk);
        #1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_z     = z;
        bus.in_w     = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x     = $urandom;
        bus.in_y     = $urandom;
        bus.in_z     = $urandom;
        bus.in_w     = $urandom;
    endtask

    // Wait for the result and pin it against hand-computed values
    task automatic checkOutput(input string name, input logic [31:0] ex, input logic [31:0] ey,
                               input logic [31:0] ez, input logic ewz);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("[TB] FAIL %s_valid_timeout: out_valid %0b, required 1", name, bus.out_valid);
        end else begin
            check_word({name, "_x"}, bus.out_x, ex);
            check_word({name, "_y"}, bus.out_y, ey);
            check_word({name, "_z"}, bus.out_z, ez);
            check_bit({name, "_wzero"}, bus.out_wzero, ewz);
        end
        @(posedge clk);
        #1;
    endtask

    // Let the current vertex drain with random back-pressure and stray in_valid pulses
    task automatic waitIdle();
        int n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (!model_busy) break;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.in_valid = 1'b1;
                bus.in_x     = $urandom;
                bus.in_w     = $urandom;
            end
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $display("[TB] FAIL drain_timeout: model still busy, out_valid %0b", bus.out_valid);
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_z      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Hand-computed pins for the model itself
        check_word("pin_model_2_over_2", model_div(32'h0002_0000, 32'h0002_0000), ONE);
        check_word("pin_model_m1_over_2", model_div(32'hFFFF_0000, 32'h0002_0000), 32'hFFFF_8000);
        check_word("pin_model_half_over_2", model_div(32'h0000_8000, 32'h0002_0000), 32'h0000_4000);
        check_word("pin_model_1_over_m4", model_div(32'h0001_0000, 32'hFFFC_0000), 32'hFFFF_C000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_in_ready", bus.in_ready, 1'b1);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] basic divides");
        applyStimulus(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        checkOutput("t1", 32'h0001_0000, 32'hFFFF_8000, 32'h0000_4000, 1'b0);
        applyStimulus(32'h0001_0000, 32'h0, 32'h0, 32'hFFFC_0000);
        checkOutput("t2", 32'hFFFF_C000, 32'h0, 32'h0, 1'b0);

        $display("[TB] w == 0");
        applyStimulus(32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
        checkOutput("t3", 32'h0, 32'h0, 32'h0, 1'b1);

        $display("[TB] output stall and back-to-back");
        bus.out_ready = 1'b0;
        applyStimulus(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        n = 0;
        while (!bus.out_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        check_bit("t4_held_valid", bus.out_valid, 1'b1);
        check_bit("t4_held_in_ready", bus.in_ready, 1'b0);
        check_word("t4_held_x", bus.out_x, 32'h0001_0000);
        bus.out_ready = 1'b1;
        applyStimulus(32'h0001_0000, 32'h0, 32'h0, 32'hFFFC_0000);
        checkOutput("t4_second", 32'hFFFF_C000, 32'h0, 32'h0, 1'b0);

        $display("[TB] input ignored while busy");
        applyStimulus(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        repeat (30) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_x     = 32'h0700_0000;
        bus.in_w     = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("t5", 32'h0001_0000, 32'hFFFF_8000, 32'h0000_4000, 1'b0);

        $display("[TB] reset during y divide");
        applyStimulus(32'h0005_0000, 32'h0003_0000, 32'h0001_0000, 32'h0003_0000);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("t6_rst_in_ready", bus.in_ready, 1'b1);
        check_bit("t6_rst_out_valid", bus.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        checkOutput("t6_after", 32'h0001_0000, 32'hFFFF_8000, 32'h0000_4000, 1'b0);

        $display("[TB] randomized vertices");
        for (int i = 0; i < 25; i++) begin
            logic [31:0] w;
            w = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_fixed();
            if (i % 8 == 3) w = 32'd0;
            else if (w == 32'd0 && i % 5 == 0) w = 32'h0000_0001;
            applyStimulus(rand_fixed(), rand_fixed(), rand_fixed(), w);
            waitIdle();
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, model busy %0b", model_busy);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
